adc_serial_capture: RTL and testbench

- Upstream stage of the sample-register chain.
- Drives a serial ADC interface (chip select, serial clock, data-in), shifts in one conversion frame MSB-first and presents the result as a parallel word.
- Issues a one-cycle valid strobe; downstream D-register stages use it as their load qualifier.
- Serial clock is derived from the system clock by an internal divider; no second clock domain.

---
 rtl/adc_serial_capture_if.sv | 44 ++++
 rtl/adc_serial_capture.sv | 158 +++++++++++++++
 tb/tb_adc_serial_capture.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_serial_capture_if.sv
// Bus between adc_serial_capture and its ADC/downstream side.
// The err strobe is present only when ADC_LEAD_CHECK_EN is defined.
interface adc_serial_capture_if #(
    parameter int unsigned DATA_W = 12
);
    logic              start;
    logic              miso;
    logic              cs_n;
    logic              sclk;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              busy;
`ifdef ADC_LEAD_CHECK_EN
    logic              err;
`endif

    // Capture block side: drives the ADC pins and the result word.
    modport master (
        input  start,
        input  miso,
        output cs_n,
        output sclk,
        output data,
        output valid,
        output busy
`ifdef ADC_LEAD_CHECK_EN
        , output err
`endif
    );

    // ADC / downstream side.
    modport slave (
        output start,
        output miso,
        input  cs_n,
        input  sclk,
        input  data,
        input  valid,
        input  busy
`ifdef ADC_LEAD_CHECK_EN
        , input err
`endif
    );
endinterface

// File: rtl/adc_serial_capture.sv
// Serial ADC frame capture: drives cs_n/sclk, shifts a frame in MSB-first, strobes the data word.
// Optional macro ADC_LEAD_CHECK_EN flags frames whose leading bits are not all zero via err.
module adc_serial_capture #(
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned LEAD_BITS = 4,
    parameter int unsigned CLK_DIV   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adc_serial_capture_if.master cap_if
);
    localparam int unsigned FRAME_BITS = LEAD_BITS + DATA_W;
    localparam int unsigned DIV_W      = $clog2(CLK_DIV + 1);
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS + 1);
`ifdef ADC_LEAD_CHECK_EN
    localparam int unsigned SHIFT_W    = FRAME_BITS;
`else
    // Leading bits fall off the top of a DATA_W-wide register on their own.
    localparam int unsigned SHIFT_W    = DATA_W;
`endif
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
`ifdef ADC_LEAD_CHECK_EN
    logic                err_q, err_d;
`endif

    // State and output registers; reset drops cs_n/sclk immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef ADC_LEAD_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
`ifdef ADC_LEAD_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Next-state and next-output decode; outputs land one edge after the decision.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        data_d  = data_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
`ifdef ADC_LEAD_CHECK_EN
        err_d   = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                busy_d = cap_if.start;
                if (cap_if.start) begin
                    state_d = S_SETUP;
                    cs_n_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end

            S_SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            // Each bit: CLK_DIV cycles low, CLK_DIV high; miso sampled on the rising decision.
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        shift_d = {shift_q[SHIFT_W-2:0], cap_if.miso};
                    end else if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
`ifdef ADC_LEAD_CHECK_EN
                if (|shift_q[SHIFT_W-1:DATA_W]) begin
                    err_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    data_d  = shift_q[DATA_W-1:0];
                end
`else
                valid_d = 1'b1;
                data_d  = shift_q;
`endif
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign cap_if.cs_n  = cs_n_q;
    assign cap_if.sclk  = sclk_q;
    assign cap_if.data  = data_q;
    assign cap_if.valid = valid_q;
    assign cap_if.busy  = busy_q;
`ifdef ADC_LEAD_CHECK_EN
    assign cap_if.err   = err_q;
`endif

endmodule

// File: tb/tb_adc_serial_capture.sv
// Self-checking bench for adc_serial_capture: behavioural ADC model plus frame-level reference.
// Builds with or without ADC_LEAD_CHECK_EN.
module tb_adc_serial_capture;
    localparam int unsigned DATA_W     = 12;
    localparam int unsigned LEAD_BITS  = 4;
    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned FRAME_BITS = LEAD_BITS + DATA_W;
    localparam int unsigned LATENCY    = CLK_DIV * (1 + 2 * FRAME_BITS) + 1;
    localparam int unsigned WAIT_MAX   = LATENCY + 40;
    localparam int unsigned RST_EDGE   = 66;

    logic clk = 1'b0;
    logic rst_n;

    adc_serial_capture_if #(.DATA_W(DATA_W)) cap_if ();

    adc_serial_capture #(
        .DATA_W   (DATA_W),
        .LEAD_BITS(LEAD_BITS),
        .CLK_DIV  (CLK_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cap_if(cap_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ADC model: one queued frame per cs_n fall, MSB first, next bit after each sclk rise.
    logic [FRAME_BITS-1:0] frame_q[$];
    logic [FRAME_BITS-1:0] adc_word = '0;
    int unsigned           adc_bit  = 0;

    always @(negedge cap_if.cs_n or posedge cap_if.sclk) begin
        if (cap_if.sclk === 1'b1) begin
            adc_bit++;
        end else begin
            adc_bit  = 0;
            adc_word = (frame_q.size() > 0) ? frame_q.pop_front() : '0;
        end
    end

    assign cap_if.miso = (adc_bit < FRAME_BITS) ? adc_word[FRAME_BITS-1-adc_bit] : 1'b0;

    int unsigned sclk_rises   = 0;
    int unsigned valid_pulses = 0;
    logic        sclk_prev    = 1'b0;

    always @(negedge clk) begin
        if (cap_if.sclk === 1'b1 && sclk_prev !== 1'b1) sclk_rises <= sclk_rises + 1;
        sclk_prev <= cap_if.sclk;
        if (cap_if.valid === 1'b1) valid_pulses <= valid_pulses + 1;
    end

    logic [DATA_W-1:0] model_data = '0;

    function automatic logic strobe_seen();
`ifdef ADC_LEAD_CHECK_EN
        return (cap_if.valid === 1'b1) || (cap_if.err === 1'b1);
`else
        return (cap_if.valid === 1'b1);
`endif
    endfunction

    // Counts edges until a result strobe; optionally pulses start once at edge extra_at.
    task automatic wait_strobe(input int extra_at, output int k, output int hold_bad);
        k        = 0;
        hold_bad = 0;
        while (k < int'(WAIT_MAX)) begin
            if (extra_at != 0 && k + 1 == extra_at) cap_if.start = 1'b1;
            @(posedge clk);
            #1;
            k++;
            if (extra_at != 0) cap_if.start = 1'b0;
            if (strobe_seen()) break;
            if (cap_if.data !== model_data) hold_bad++;
        end
    endtask

    task automatic do_frame(input logic [FRAME_BITS-1:0] f, input int extra_at, input string tag);
        int               k;
        int               hold_bad;
        int unsigned      r0;
        logic             exp_err;
        logic [DATA_W-1:0] exp_data;
        exp_err = 1'b0;
`ifdef ADC_LEAD_CHECK_EN
        exp_err = ((f >> DATA_W) != 0);
`endif
        exp_data = exp_err ? model_data : f[DATA_W-1:0];
        frame_q.push_back(f);
        r0 = sclk_rises;
        cap_if.start = 1'b1;
        @(posedge clk);
        #1;
        cap_if.start = 1'b0;
        check({tag, ".cs_n_accept"}, 32'(cap_if.cs_n), 32'd0);
        check({tag, ".busy_accept"}, 32'(cap_if.busy), 32'd1);
        wait_strobe(extra_at, k, hold_bad);
        check({tag, ".latency"}, k, LATENCY);
        check({tag, ".valid"}, 32'(cap_if.valid), 32'(!exp_err));
`ifdef ADC_LEAD_CHECK_EN
        check({tag, ".err"}, 32'(cap_if.err), 32'(exp_err));
`endif
        check({tag, ".data"}, 32'(cap_if.data), 32'(exp_data));
        check({tag, ".cs_n_done"}, 32'(cap_if.cs_n), 32'd1);
        check({tag, ".sclk_done"}, 32'(cap_if.sclk), 32'd0);
        check({tag, ".busy_done"}, 32'(cap_if.busy), 32'd1);
        check({tag, ".data_hold"}, hold_bad, 32'd0);
        @(posedge clk);
        #1;
        check({tag, ".valid_one_cycle"}, 32'(cap_if.valid), 32'd0);
`ifdef ADC_LEAD_CHECK_EN
        check({tag, ".err_one_cycle"}, 32'(cap_if.err), 32'd0);
`endif
        check({tag, ".busy_after"}, 32'(cap_if.busy), 32'd0);
        check({tag, ".sclk_rises"}, sclk_rises - r0, FRAME_BITS);
        model_data = exp_data;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          hold_bad;
        int          gap;
        int          dev;
        int unsigned v0;
        int unsigned r0;
        logic [FRAME_BITS-1:0] f;

        rst_n        = 1'b0;
        cap_if.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.cs_n", 32'(cap_if.cs_n), 32'd1);
        check("rst.sclk", 32'(cap_if.sclk), 32'd0);
        check("rst.data", 32'(cap_if.data), 32'd0);
        check("rst.valid", 32'(cap_if.valid), 32'd0);
        check("rst.busy", 32'(cap_if.busy), 32'd0);
        rst_n = 1'b1;
        dev = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (cap_if.cs_n !== 1'b1 || cap_if.sclk !== 1'b0 || cap_if.valid !== 1'b0 ||
                cap_if.busy !== 1'b0 || cap_if.data !== '0) dev++;
        end
        check("idle.deviations", dev, 32'd0);

        // Reset in the middle of a frame, while sclk is high.
        frame_q.push_back(FRAME_BITS'(16'h0ABC));
        v0 = valid_pulses;
        cap_if.start = 1'b1;
        @(posedge clk);
        #1;
        cap_if.start = 1'b0;
        repeat (RST_EDGE - 1) @(posedge clk);
        #1;
        check("midrst.sclk_before", 32'(cap_if.sclk), 32'd1);
        check("midrst.cs_n_before", 32'(cap_if.cs_n), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst.cs_n", 32'(cap_if.cs_n), 32'd1);
        check("midrst.sclk", 32'(cap_if.sclk), 32'd0);
        check("midrst.busy", 32'(cap_if.busy), 32'd0);
        check("midrst.data", 32'(cap_if.data), 32'(model_data));
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check("midrst.no_valid", valid_pulses - v0, 32'd0);
        check("midrst.cs_n_idle", 32'(cap_if.cs_n), 32'd1);
        check("midrst.data_idle", 32'(cap_if.data), 32'(model_data));

        do_frame({4'h0, 12'hA5C}, 0, "single");

        // Second start during the frame must be ignored.
        v0 = valid_pulses;
        r0 = sclk_rises;
        do_frame({4'h0, 12'h3E1}, 40, "busy_start");
        repeat (200) @(posedge clk);
        #1;
        check("busy_start.valid_count", valid_pulses - v0, 32'd1);
        check("busy_start.sclk_total", sclk_rises - r0, FRAME_BITS);
        check("busy_start.idle_cs_n", 32'(cap_if.cs_n), 32'd1);

        // Start held high: two frames separated by a single cs_n-high cycle.
        frame_q.push_back({4'h0, 12'h001});
        frame_q.push_back({4'h0, 12'hFFF});
        v0 = valid_pulses;
        cap_if.start = 1'b1;
        @(posedge clk);
        #1;
        wait_strobe(0, k, hold_bad);
        check("held.latency1", k, LATENCY);
        check("held.data1", 32'(cap_if.data), 32'h001);
        model_data = 12'h001;
        gap = 0;
        while (cap_if.cs_n === 1'b1 && gap < 10) begin
            gap++;
            @(posedge clk);
            #1;
        end
        check("held.cs_n_gap", gap, 32'd1);
        wait_strobe(0, k, hold_bad);
        cap_if.start = 1'b0;
        check("held.valid_spacing", gap + k, LATENCY + 1);
        check("held.data2", 32'(cap_if.data), 32'hFFF);
        check("held.hold2", hold_bad, 32'd0);
        model_data = 12'hFFF;
        repeat (5) @(posedge clk);
        #1;
        check("held.valid_count", valid_pulses - v0, 32'd2);
        check("held.busy_end", 32'(cap_if.busy), 32'd0);

`ifdef ADC_LEAD_CHECK_EN
        do_frame({4'b0100, 12'h3C7}, 0, "lead_err");
        do_frame({4'b0000, 12'h3C7}, 0, "lead_ok");
`endif

        for (int i = 0; i < 8; i++) begin
            f = FRAME_BITS'($urandom);
`ifdef ADC_LEAD_CHECK_EN
            if ($urandom_range(0, 1) == 0) f[FRAME_BITS-1:DATA_W] = '0;
`endif
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            do_frame(f, 0, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
